// File: rtl/vedic_seq_multiplier.sv
// Column-serial Urdhva-Tiryagbhyam multiplier: one crosswise column of a*b per clock.
// Latency: 2*WIDTH-1 cycles from operand accept to out_valid.
// Backpressure: product/out_valid held while out_ready=0; in_ready low until result is taken.
module vedic_seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  // Column accumulator must hold carry + column popcount (each <= WIDTH).
  localparam int CW = $clog2(WIDTH) + 2;
  localparam int KW = $clog2(2 * WIDTH);
  localparam int IW = $clog2(WIDTH);
  localparam logic [KW-1:0] K_LAST = KW'(2 * WIDTH - 2);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPUTE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [KW-1:0]      r_k;
  logic [CW-1:0]      r_carry;
  logic [2*WIDTH-1:0] r_product;

  logic [KW-1:0]      w_j;
  logic [CW-1:0]      w_col_sum;
  logic [CW-1:0]      w_acc;

  // Popcount of the k-th anti-diagonal: a[i]&b[k-i] for every row i that lands inside b.
  always_comb begin
    w_col_sum = '0;
    w_j       = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_j = r_k - KW'(i);
      if ((r_k >= KW'(i)) && (w_j < KW'(WIDTH))) begin
        w_col_sum = w_col_sum + CW'(r_a[i] & r_b[w_j[IW-1:0]]);
      end
    end
  end

  assign w_acc = r_carry + w_col_sum;

  // Control FSM and column datapath; the last column also yields the product MSB from its carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_k       <= '0;
      r_carry   <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a       <= a;
            r_b       <= b;
            r_k       <= '0;
            r_carry   <= '0;
            r_product <= '0;
            r_state   <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          r_product[r_k] <= w_acc[0];
          r_carry        <= w_acc >> 1;
          r_k            <= r_k + KW'(1);
          if (r_k == K_LAST) begin
            r_product[2*WIDTH-1] <= w_acc[1];
            r_state              <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign product   = r_product;

endmodule

// File: tb/tb_vedic_seq_multiplier.sv
// Self-checking bench for vedic_seq_multiplier at WIDTH=8, 16 and 4.
// Reference is plain integer multiplication plus a queue of accepted operands.
module tb_vedic_seq_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic iv   [3];
  logic ordy [3];
  logic irdy [3];
  logic ovld [3];
  logic bsy  [3];
  logic [7:0]  a8,  b8;
  logic [15:0] a16, b16;
  logic [3:0]  a4,  b4;
  logic [15:0] p8;
  logic [31:0] p16;
  logic [7:0]  p4;

  int ncmp  = 0;
  int nfail = 0;

  vedic_seq_multiplier #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]), .a(a8), .b(b8),
    .out_valid(ovld[0]), .out_ready(ordy[0]), .product(p8), .busy(bsy[0]));

  vedic_seq_multiplier #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]), .a(a16), .b(b16),
    .out_valid(ovld[1]), .out_ready(ordy[1]), .product(p16), .busy(bsy[1]));

  vedic_seq_multiplier #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]), .a(a4), .b(b4),
    .out_valid(ovld[2]), .out_ready(ordy[2]), .product(p4), .busy(bsy[2]));

  function automatic int wd(input int d);
    return (d == 0) ? 8 : (d == 1) ? 16 : 4;
  endfunction

  function automatic logic [63:0] prod(input int d);
    case (d)
      0:       return 64'(p8);
      1:       return 64'(p16);
      default: return 64'(p4);
    endcase
  endfunction

  // Reference: the full unsigned product of the WIDTH-bit operands.
  function automatic logic [63:0] model(input int d, input logic [31:0] av, input logic [31:0] bv);
    logic [63:0] m;
    m = (64'd1 << wd(d)) - 64'd1;
    return (64'(av) & m) * (64'(bv) & m);
  endfunction

  task automatic set_in(input int d, input logic v, input logic [31:0] av, input logic [31:0] bv,
                        input logic r);
    iv[d]   = v;
    ordy[d] = r;
    case (d)
      0:       begin a8  = av[7:0];  b8  = bv[7:0];  end
      1:       begin a16 = av[15:0]; b16 = bv[15:0]; end
      default: begin a4  = av[3:0];  b4  = bv[3:0];  end
    endcase
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction with out_ready held high; checks latency, product and handshake timing.
  task automatic do_op(input int d, input logic [31:0] av, input logic [31:0] bv, input string tag);
    int          n;
    logic        ok;
    logic [63:0] exp_p;
    exp_p = model(d, av, bv);
    set_in(d, 1'b1, av, bv, 1'b1);
    tick;
    set_in(d, 1'b0, ~av, ~bv, 1'b1);
    n  = 0;
    ok = 1'b1;
    while (!ovld[d] && n < 100) begin
      if (irdy[d] !== 1'b0 || bsy[d] !== 1'b1) ok = 1'b0;
      tick;
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(2 * wd(d) - 1));
    check({tag, " product"}, prod(d), exp_p);
    check({tag, " busy_no_ready"}, 64'(ok & ~irdy[d] & bsy[d]), 64'd1);
    tick;
    check({tag, " out_valid_drop"}, 64'(ovld[d]), 64'd0);
    check({tag, " in_ready_back"}, 64'(irdy[d]), 64'd1);
    ordy[d] = 1'b0;
  endtask

  // Random traffic with random in_valid / out_ready; scoreboard checks order, value and latency.
  task automatic rand_run(input int d, input int nops);
    logic [63:0] q_exp[$];
    int          q_t[$];
    int          cyc, got, sent, guard, lat;
    logic        prev_ov, in_fire, out_fire;
    logic [63:0] p_snap;
    logic [31:0] ra, rb;
    lat = 2 * wd(d) - 1;
    cyc = 0; got = 0; sent = 0; guard = 0;
    prev_ov = 1'b0;
    while (got < nops && guard < nops * (4 * wd(d) + 40)) begin
      if (ovld[d] && !prev_ov) begin
        if (q_t.size() == 0) check("rand out_valid_without_accept", 64'd1, 64'd0);
        else check("rand latency", 64'(cyc - q_t[0]), 64'(lat));
      end
      prev_ov = ovld[d];
      ra = $urandom;
      rb = $urandom;
      set_in(d, (sent < nops) && ($urandom_range(0, 1) == 1), ra, rb, $urandom_range(0, 2) != 0);
      in_fire  = iv[d] && irdy[d];
      out_fire = ovld[d] && ordy[d];
      p_snap   = prod(d);
      tick;
      cyc++;
      guard++;
      if (in_fire) begin
        q_exp.push_back(model(d, ra, rb));
        q_t.push_back(cyc);
        sent++;
      end
      if (out_fire) begin
        if (q_exp.size() == 0) check("rand duplicate_transfer", 64'd1, 64'd0);
        else begin
          check("rand product", p_snap, q_exp.pop_front());
          void'(q_t.pop_front());
        end
        got++;
      end
    end
    set_in(d, 1'b0, 32'd0, 32'd0, 1'b0);
    check("rand transfers_received", 64'(got), 64'(nops));
    check("rand queue_drained", 64'(q_exp.size()), 64'd0);
  endtask

  initial begin
    int          n;
    logic        stable;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) set_in(d, 1'b0, 32'd0, 32'd0, 1'b0);
    #12;
    for (int d = 0; d < 3; d++) begin
      check("reset in_ready", 64'(irdy[d]), 64'd1);
      check("reset out_valid", 64'(ovld[d]), 64'd0);
      check("reset busy", 64'(bsy[d]), 64'd0);
      check("reset product", prod(d), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick;

    // Directed WIDTH=8 cases, including all-ones corner.
    do_op(0, 32'hFF, 32'hFF, "w8 FFxFF");
    check("w8 FFxFF value", prod(0), 64'hFE01);
    do_op(0, 32'h00, 32'hA5, "w8 00xA5");
    do_op(0, 32'h01, 32'hA5, "w8 01xA5");
    do_op(0, 32'h0F, 32'hF0, "w8 0FxF0");
    do_op(0, 32'h80, 32'h80, "w8 80x80");

    // Backpressure: hold result for 10 cycles while stray in_valid pulses arrive.
    set_in(0, 1'b1, 32'h12, 32'h34, 1'b0);
    tick;
    set_in(0, 1'b0, 32'h55, 32'h66, 1'b0);
    n = 0;
    while (!ovld[0] && n < 100) begin tick; n++; end
    check("bp latency", 64'(n), 64'd15);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_in(0, i[0], $urandom, $urandom, 1'b0);
      tick;
      if (ovld[0] !== 1'b1 || prod(0) !== 64'h03A8 || irdy[0] !== 1'b0) stable = 1'b0;
    end
    check("bp held_stable", 64'(stable), 64'd1);
    set_in(0, 1'b0, 32'd0, 32'd0, 1'b1);
    tick;
    check("bp out_valid_drop", 64'(ovld[0]), 64'd0);
    check("bp in_ready_back", 64'(irdy[0]), 64'd1);
    ordy[0] = 1'b0;
    tick;
    check("bp single_transfer", 64'(ovld[0]), 64'd0);
    check("bp idle_keeps_product", prod(0), 64'h03A8);

    // Asynchronous reset at column k=5, away from any clock edge.
    set_in(0, 1'b1, 32'hAB, 32'hCD, 1'b0);
    tick;
    set_in(0, 1'b0, 32'hAB, 32'hCD, 1'b0);
    repeat (5) tick;
    #2 rst_n = 1'b0;
    #1;
    check("midrst in_ready", 64'(irdy[0]), 64'd1);
    check("midrst out_valid", 64'(ovld[0]), 64'd0);
    check("midrst busy", 64'(bsy[0]), 64'd0);
    check("midrst product", prod(0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    check("postrst idle", 64'(ovld[0]), 64'd0);
    do_op(0, 32'h07, 32'h09, "w8 post-reset 07x09");
    check("w8 post-reset value", prod(0), 64'h003F);

    // WIDTH=4 instance.
    do_op(2, 32'hF, 32'hF, "w4 FxF");
    check("w4 FxF value", prod(2), 64'hE1);
    do_op(2, 32'hA, 32'h3, "w4 Ax3");
    check("w4 Ax3 value", prod(2), 64'h1E);

    // Random traffic on WIDTH=8 and WIDTH=16 concurrently.
    fork
      rand_run(0, 1000);
      rand_run(1, 600);
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
